// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman encoder pipeline: symbol/count widths
// and the frequency-counter state encoding.
package huffman_pkg;

    localparam int NUM_SYMS = 10;
    localparam int CNT_W    = 9;
    localparam int TREE_W   = 15;
    localparam int SYM_W    = 4;

    typedef enum logic [1:0] {
        S_COUNT = 2'd0,
        S_START = 2'd1,
        S_HOLD  = 2'd2,
        S_CLEAR = 2'd3
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/huff_count_bin.sv
// One histogram bin: clearable up-counter; clear wins over increment.
module huff_count_bin
    import huffman_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/huffman_freq_counter.sv
// Symbol histogram front-end: counts a block of decimal symbols, requests a
// tree build, holds the counts frozen, then clears for the next block.
module huffman_freq_counter
    import huffman_pkg::*;
#(
    parameter int BLOCK_LEN    = 256,
    parameter int START_CYCLES = 20,
    parameter int HOLD_CYCLES  = 64
) (
    input  logic             Clk_in,
    input  logic             n_Rst,
    input  logic             Sym_valid,
    input  logic [SYM_W-1:0] Sym_in,
    input  logic             Sym_last,
    output logic             Sym_ready,
    output logic [CNT_W-1:0] Num0,
    output logic [CNT_W-1:0] Num1,
    output logic [CNT_W-1:0] Num2,
    output logic [CNT_W-1:0] Num3,
    output logic [CNT_W-1:0] Num4,
    output logic [CNT_W-1:0] Num5,
    output logic [CNT_W-1:0] Num6,
    output logic [CNT_W-1:0] Num7,
    output logic [CNT_W-1:0] Num8,
    output logic [CNT_W-1:0] Num9,
    output logic             Start_tree,
    output logic [CNT_W-1:0] Blk_total,
    output logic [7:0]       Err_cnt,
    output state_e           dbg_state
);

    localparam int PH_MAX = max_int(START_CYCLES, HOLD_CYCLES);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [7:0]        err_q, err_d;

    logic                accept, legal, close, empty, clr;
    logic [NUM_SYMS-1:0] bin_inc;
    logic [CNT_W-1:0]    bin_cnt [NUM_SYMS];
    logic [CNT_W-1:0]    blk_cnt;

    // Handshake: a beat transfers on a cycle where Sym_valid and Sym_ready are
    // both high; Sym_ready is high only in COUNT and never while n_Rst is low.
    assign Sym_ready = n_Rst & (state_q == S_COUNT);
    assign accept    = Sym_valid & Sym_ready;
    assign legal     = Sym_in < SYM_W'(NUM_SYMS);
    assign clr       = (state_q == S_CLEAR);
    assign close     = accept & (Sym_last | (legal & (blk_cnt == CNT_W'(BLOCK_LEN - 1))));
    assign empty     = ~legal & (blk_cnt == '0);

    always_comb begin
        for (int i = 0; i < NUM_SYMS; i++) begin
            bin_inc[i] = accept & legal & (Sym_in == SYM_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_SYMS; g++) begin : g_bin
        huff_count_bin #(.W(CNT_W)) u_bin (
            .clk   (Clk_in),
            .rst_n (n_Rst),
            .clr   (clr),
            .inc   (bin_inc[g]),
            .cnt   (bin_cnt[g])
        );
    end

    huff_count_bin #(.W(CNT_W)) u_total (
        .clk   (Clk_in),
        .rst_n (n_Rst),
        .clr   (clr),
        .inc   (accept & legal),
        .cnt   (blk_cnt)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        err_d   = err_q;
        if (accept && !legal && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
        case (state_q)
            S_COUNT: begin
                if (close) begin
                    state_d = empty ? S_CLEAR : S_START;
                    phase_d = '0;
                end
            end
            S_START: begin
                if (phase_q == PH_W'(START_CYCLES - 1)) begin
                    state_d = S_HOLD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_HOLD: begin
                if (phase_q == PH_W'(HOLD_CYCLES - 1)) begin
                    state_d = S_CLEAR;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_CLEAR: state_d = S_COUNT;
            default: state_d = S_COUNT;
        endcase
    end

    always_ff @(posedge Clk_in) begin
        if (!n_Rst) begin
            state_q <= S_COUNT;
            phase_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            err_q   <= err_d;
        end
    end

    assign Start_tree = (state_q == S_START);
    assign Blk_total  = blk_cnt;
    assign Err_cnt    = err_q;
    assign dbg_state  = state_q;

    assign Num0 = bin_cnt[0];
    assign Num1 = bin_cnt[1];
    assign Num2 = bin_cnt[2];
    assign Num3 = bin_cnt[3];
    assign Num4 = bin_cnt[4];
    assign Num5 = bin_cnt[5];
    assign Num6 = bin_cnt[6];
    assign Num7 = bin_cnt[7];
    assign Num8 = bin_cnt[8];
    assign Num9 = bin_cnt[9];

endmodule
